vec_vsetvl_ctrl: RTL and testbench

- Sequences vector-configuration instructions (vsetvli, vsetivli, vsetvl) from the scalar-processor request channel into the vector CSR register file.
- Decodes the instruction, validates the requested vtype, computes VLMAX and the new vl, drives the CSR write strobe and waits for the CSR-done acknowledge.
- Returns the new vl for the scalar rd writeback.
- Sits between the scalar issue interface and the vector CSR register file.

---
 rtl/vec_cfg_pkg.sv | 40 ++++
 rtl/vec_vlmax_calc.sv | 36 +++
 rtl/vec_vsetvl_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vec_vsetvl_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_cfg_pkg.sv
// Shared vector-configuration definitions: FSM states, vtype field encodings
// and the OP-V / OPCFG decode constants.
package vec_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WRITE,
        WAIT,
        RESP
    } vset_state_e;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        SEW_8  = 3'b000,
        SEW_16 = 3'b001,
        SEW_32 = 3'b010,
        SEW_64 = 3'b011
    } vew_e;

    localparam logic [6:0] OPC_VECTOR = 7'h57;
    localparam logic [2:0] F3_OPCFG   = 3'b111;

    localparam int unsigned VTYPE_VLMUL_LSB = 0;
    localparam int unsigned VTYPE_VSEW_LSB  = 3;
    localparam int unsigned VTYPE_VTA_BIT   = 6;
    localparam int unsigned VTYPE_VMA_BIT   = 7;
    localparam int unsigned VTYPE_W         = 8;

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational vtype checker: flags illegal vtype encodings and computes
// VLMAX = VLEN * LMUL / SEW for integral LMUL only.
module vec_vlmax_calc
    import vec_cfg_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned VLEN    = 512,
    parameter int unsigned VLMAX_W = $clog2(VLEN + 1)
) (
    input  logic [XLEN-1:0]    vtype,
    output logic [VLMAX_W-1:0] vlmax,
    output logic               vill
);

    vlmul_e lmul;
    vew_e   sew;
    logic   unused_policy_bits;

    // vta/vma do not affect VLMAX or legality
    assign unused_policy_bits = vtype[VTYPE_VTA_BIT] ^ vtype[VTYPE_VMA_BIT];

    always_comb begin
        lmul = vlmul_e'(vtype[VTYPE_VLMUL_LSB +: 3]);
        sew  = vew_e'(vtype[VTYPE_VSEW_LSB +: 3]);
        vill = (|vtype[XLEN-1:VTYPE_W])
            || !(lmul inside {LMUL_1, LMUL_2, LMUL_4, LMUL_8})
            || !(sew inside {SEW_8, SEW_16, SEW_32, SEW_64});
        // VLEN/8 elements at e8,m1; each SEW step halves, each LMUL step doubles
        vlmax = VLMAX_W'(((32'(VLEN) >> 3) >> vtype[VTYPE_VSEW_LSB +: 2])
                         << vtype[VTYPE_VLMUL_LSB +: 2]);
        if (vill) begin
            vlmax = '0;
        end
    end

endmodule

// File: rtl/vec_vsetvl_ctrl.sv
// Sequences vsetvli/vsetivli/vsetvl: decode, vtype check, vl selection,
// one-cycle CSR write strobe, csr_done wait with timeout, rd response.
module vec_vsetvl_ctrl
    import vec_cfg_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned VLEN         = 512,
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_inst,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [XLEN-1:0] req_rs2_val,
    input  logic [XLEN-1:0] cur_vl,
    output logic            csrwr_en,
    output logic [XLEN-1:0] csr_vtype,
    output logic [XLEN-1:0] csr_vl,
    output logic            vstart_clr,
    input  logic            csr_done,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rd_val,
    output logic            resp_vill,
    output logic            resp_illegal,
    output logic            resp_timeout
);

    localparam int unsigned VLMAX_W = $clog2(VLEN + 1);
    localparam int unsigned CNT_W   = $clog2(DONE_TIMEOUT + 1);

    vset_state_e     state;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic            opc_ok;
    logic            is_vli;
    logic            is_vili;
    logic            is_vl;
    logic [4:0]      rd_idx;
    logic [4:0]      rs1_idx;
    logic [XLEN-1:0] vtype_sel;
    logic [XLEN-1:0] vlmax_x;
    logic [XLEN-1:0] vl_calc;
    logic            vl_vill;
    logic [VLMAX_W-1:0] vlmax;
    logic            calc_vill;

    vec_vlmax_calc #(
        .XLEN   (XLEN),
        .VLEN   (VLEN),
        .VLMAX_W(VLMAX_W)
    ) u_vlmax (
        .vtype(vtype_sel),
        .vlmax(vlmax),
        .vill (calc_vill)
    );

    always_comb begin
        opc_ok  = (inst_q[6:0] == OPC_VECTOR) && (inst_q[14:12] == F3_OPCFG);
        is_vli  = opc_ok && !inst_q[31];
        is_vili = opc_ok && (inst_q[31:30] == 2'b11);
        is_vl   = opc_ok && (inst_q[31:25] == 7'b1000000);
        rd_idx  = inst_q[11:7];
        rs1_idx = inst_q[19:15];

        if (is_vli) begin
            vtype_sel = XLEN'(inst_q[30:20]);
        end else if (is_vili) begin
            vtype_sel = XLEN'(inst_q[29:20]);
        end else begin
            vtype_sel = rs2_q;
        end

        vlmax_x = XLEN'(vlmax);
        vl_vill = 1'b0;
        // full-width unsigned compare so large AVLs never alias after truncation
        if (is_vili) begin
            vl_calc = (XLEN'(rs1_idx) < vlmax_x) ? XLEN'(rs1_idx) : vlmax_x;
        end else if (rs1_idx != 5'd0) begin
            vl_calc = (rs1_q < vlmax_x) ? rs1_q : vlmax_x;
        end else if (rd_idx != 5'd0) begin
            vl_calc = vlmax_x;
        end else begin
            vl_calc = cur_vl;
            vl_vill = (cur_vl > vlmax_x);
        end
    end

    assign cnt_next = cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            inst_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            cnt          <= '0;
            req_ready    <= 1'b1;
            csrwr_en     <= 1'b0;
            vstart_clr   <= 1'b0;
            csr_vtype    <= '0;
            csr_vl       <= '0;
            resp_valid   <= 1'b0;
            resp_rd_val  <= '0;
            resp_vill    <= 1'b0;
            resp_illegal <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        inst_q    <= req_inst;
                        rs1_q     <= req_rs1_val;
                        rs2_q     <= req_rs2_val;
                        req_ready <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    cnt <= '0;
                    if (!(is_vli || is_vili || is_vl)) begin
                        resp_valid   <= 1'b1;
                        resp_illegal <= 1'b1;
                        resp_rd_val  <= '0;
                        state        <= RESP;
                    end else if (calc_vill || vl_vill) begin
                        resp_valid  <= 1'b1;
                        resp_vill   <= 1'b1;
                        resp_rd_val <= '0;
                        state       <= RESP;
                    end else begin
                        csrwr_en   <= 1'b1;
                        vstart_clr <= 1'b1;
                        csr_vtype  <= XLEN'(vtype_sel[VTYPE_W-1:0]);
                        csr_vl     <= vl_calc;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    csrwr_en   <= 1'b0;
                    vstart_clr <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // a late csr_done in the final cycle still counts as success
                    if (csr_done) begin
                        resp_valid  <= 1'b1;
                        resp_rd_val <= csr_vl;
                        state       <= RESP;
                    end else if (cnt_next == CNT_W'(DONE_TIMEOUT)) begin
                        cnt          <= cnt_next;
                        resp_valid   <= 1'b1;
                        resp_timeout <= 1'b1;
                        resp_rd_val  <= '0;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid   <= 1'b0;
                        resp_rd_val  <= '0;
                        resp_vill    <= 1'b0;
                        resp_illegal <= 1'b0;
                        resp_timeout <= 1'b0;
                        req_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_vsetvl_ctrl.sv
// Scoreboard bench for vec_vsetvl_ctrl: directed vset* vectors push expected
// CSR writes and responses; a monitor pops and compares as the DUT presents them.
module tb_vec_vsetvl_ctrl;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [XLEN-1:0] req_inst = '0;
    logic [XLEN-1:0] req_rs1_val = '0;
    logic [XLEN-1:0] req_rs2_val = '0;
    logic [XLEN-1:0] cur_vl = '0;
    logic            csrwr_en;
    logic [XLEN-1:0] csr_vtype;
    logic [XLEN-1:0] csr_vl;
    logic            vstart_clr;
    logic            csr_done = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_rd_val;
    logic            resp_vill;
    logic            resp_illegal;
    logic            resp_timeout;

    vec_vsetvl_ctrl #(
        .XLEN        (32),
        .VLEN        (512),
        .DONE_TIMEOUT(15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_inst    (req_inst),
        .req_rs1_val (req_rs1_val),
        .req_rs2_val (req_rs2_val),
        .cur_vl      (cur_vl),
        .csrwr_en    (csrwr_en),
        .csr_vtype   (csr_vtype),
        .csr_vl      (csr_vl),
        .vstart_clr  (vstart_clr),
        .csr_done    (csr_done),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rd_val (resp_rd_val),
        .resp_vill   (resp_vill),
        .resp_illegal(resp_illegal),
        .resp_timeout(resp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        vill;
        logic        ill;
        logic        tmo;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] vtype;
        logic [31:0] vl;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    done_delay = 0;
    int    ready_delay = 0;
    logic  pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_vsetvli(input logic [10:0] vt, input logic [4:0] rs1, input logic [4:0] rd);
        return {1'b0, vt, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] f_vsetivli(input logic [9:0] vt, input logic [4:0] uimm, input logic [4:0] rd);
        return {2'b11, vt, uimm, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] f_vsetvl(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction

    task automatic exp_wr(input logic [31:0] vt, input logic [31:0] vl);
        wr_t w;
        w.vtype = vt;
        w.vl    = vl;
        wr_q.push_back(w);
    endtask

    task automatic exp_resp(input logic [31:0] rd, input logic vill, input logic ill,
                            input logic tmo, input int lat);
        resp_t r;
        r.rd = rd; r.vill = vill; r.ill = ill; r.tmo = tmo; r.lat = lat;
        resp_q.push_back(r);
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] rs1v, input logic [31:0] rs2v);
        logic ok;
        ok = 1'b0;
        req_inst    = inst;
        req_rs1_val = rs1v;
        req_rs2_val = rs2v;
        req_valid   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_accept: req_ready never high for inst 0x%0h", inst);
            req_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_quiet(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (req_ready && !resp_valid && resp_q.size() == 0 && wr_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got resp_q=%0d wr_q=%0d expected both 0", name,
                     resp_q.size(), wr_q.size());
            resp_q.delete();
            wr_q.delete();
        end
    endtask

    // CSR register file model: acknowledge done_delay WAIT cycles after the strobe
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && csrwr_en && done_delay >= 0) begin
                repeat (done_delay + 1) @(posedge clk);
                #1 csr_done = 1'b1;
                @(posedge clk);
                #1 csr_done = 1'b0;
            end
        end
    end

    // consumer: holds resp_ready low for ready_delay cycles of each response
    initial begin
        int rwait;
        rwait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                resp_ready = 1'b0;
                rwait = 0;
            end else if (resp_valid && !resp_ready) begin
                if (rwait >= ready_delay) resp_ready = 1'b1;
                else rwait++;
            end else if (resp_ready) begin
                resp_ready = 1'b0;
                rwait = 0;
            end
        end
    end

    initial begin : monitor
        resp_t e;
        wr_t   w;
        logic  prev_wr;
        logic [35:0] held;
        prev_wr = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wr = 1'b0;
                pending = 1'b0;
            end else begin
                if (csrwr_en || vstart_clr) begin
                    chk("vstart_with_wr", 64'(vstart_clr), 64'(csrwr_en));
                end
                if (csrwr_en) begin
                    chk("wr_gap", 64'(prev_wr), 64'(0));
                    chk("wr_latency", 64'(cyc - acc_cyc), 64'(2));
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wr: got csrwr_en=1 vl=0x%0h expected no write", csr_vl);
                    end else begin
                        w = wr_q.pop_front();
                        chk("csr_vtype", 64'(csr_vtype), 64'(w.vtype));
                        chk("csr_vl", 64'(csr_vl), 64'(w.vl));
                    end
                end
                prev_wr = csrwr_en;

                if (resp_valid && !pending) begin
                    pending = 1'b1;
                    held = {resp_rd_val, resp_vill, resp_illegal, resp_timeout, req_ready};
                    chk("req_ready_busy", 64'(req_ready), 64'(0));
                    if (resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got rd=0x%0h expected no response", resp_rd_val);
                    end else begin
                        e = resp_q.pop_front();
                        chk("resp_rd_val", 64'(resp_rd_val), 64'(e.rd));
                        chk("resp_vill", 64'(resp_vill), 64'(e.vill));
                        chk("resp_illegal", 64'(resp_illegal), 64'(e.ill));
                        chk("resp_timeout", 64'(resp_timeout), 64'(e.tmo));
                        if (e.lat >= 0) chk("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
                    end
                end else if (resp_valid) begin
                    chk("resp_stable",
                        64'({resp_rd_val, resp_vill, resp_illegal, resp_timeout, req_ready}),
                        64'(held));
                end
                if (resp_valid && resp_ready) pending = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        // reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_outputs", 64'({csrwr_en, vstart_clr, resp_valid, resp_vill, resp_illegal, resp_timeout}), 64'(0));
        chk("rst_data", 64'({csr_vl, csr_vtype, resp_rd_val}), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic vsetvli/vsetivli/vsetvl with latency checks
        exp_wr(32'h11, 32'd32); exp_resp(32'd32, 0, 0, 0, 4);
        issue(f_vsetvli(11'h011, 5'd5, 5'd1), 32'd100, 32'd0);
        wait_quiet("vsetvli_e32m2");
        exp_wr(32'h00, 32'd7); exp_resp(32'd7, 0, 0, 0, 4);
        issue(f_vsetivli(10'h000, 5'd7, 5'd2), 32'd0, 32'd0);
        wait_quiet("vsetivli_7");
        exp_wr(32'h1B, 32'd64); exp_resp(32'd64, 0, 0, 0, 4);
        issue(f_vsetvl(5'd6, 5'd0, 5'd3), 32'd0, 32'h1B);
        wait_quiet("vsetvl_vlmax");

        // illegal vtype and illegal instruction: no write, response after CALC
        exp_resp(32'd0, 1, 0, 0, 2);
        issue(f_vsetvli(11'h028, 5'd5, 5'd1), 32'd10, 32'd0);
        exp_resp(32'd0, 1, 0, 0, 2);
        issue(f_vsetvli(11'h005, 5'd5, 5'd1), 32'd10, 32'd0);
        exp_resp(32'd0, 1, 0, 0, 2);
        issue(f_vsetvl(5'd6, 5'd5, 5'd1), 32'd4, 32'h8000_0011);
        exp_resp(32'd0, 1, 0, 0, 2);
        issue(f_vsetvl(5'd6, 5'd5, 5'd1), 32'd4, 32'h0000_0100);
        exp_resp(32'd0, 0, 1, 0, 2);
        issue(32'h0000_0033, 32'd4, 32'd0);
        exp_resp(32'd0, 0, 1, 0, 2);
        issue({1'b0, 11'h011, 5'd5, 3'b110, 5'd1, 7'h57}, 32'd4, 32'd0);
        exp_resp(32'd0, 0, 1, 0, 2);
        issue({7'b1000001, 5'd6, 5'd5, 3'b111, 5'd1, 7'h57}, 32'd4, 32'h11);
        wait_quiet("illegal_cases");

        // AVL clamping at the VLMAX=512 boundary, x0 forms, vsetivli limits
        exp_wr(32'h03, 32'd512); exp_resp(32'd512, 0, 0, 0, 4);
        issue(f_vsetvli(11'h003, 5'd5, 5'd1), 32'h0000_0400, 32'd0);
        exp_wr(32'h03, 32'd512); exp_resp(32'd512, 0, 0, 0, 4);
        issue(f_vsetvli(11'h003, 5'd5, 5'd1), 32'hFFFF_FFFF, 32'd0);
        exp_wr(32'h03, 32'd511); exp_resp(32'd511, 0, 0, 0, 4);
        issue(f_vsetvli(11'h003, 5'd5, 5'd1), 32'd511, 32'd0);
        exp_wr(32'h0A, 32'd128); exp_resp(32'd128, 0, 0, 0, 4);
        issue(f_vsetvli(11'h00A, 5'd0, 5'd1), 32'd3, 32'd0);
        cur_vl = 32'd16;
        exp_wr(32'h10, 32'd16); exp_resp(32'd16, 0, 0, 0, 4);
        issue(f_vsetvli(11'h010, 5'd0, 5'd0), 32'd0, 32'd0);
        wait_quiet("keep_vl");
        cur_vl = 32'd17;
        exp_resp(32'd0, 1, 0, 0, 2);
        issue(f_vsetvli(11'h010, 5'd0, 5'd0), 32'd0, 32'd0);
        exp_wr(32'h18, 32'd8); exp_resp(32'd8, 0, 0, 0, 4);
        issue(f_vsetivli(10'h018, 5'd31, 5'd1), 32'd0, 32'd0);
        exp_wr(32'h00, 32'd0); exp_resp(32'd0, 0, 0, 0, 4);
        issue(f_vsetivli(10'h000, 5'd0, 5'd1), 32'd0, 32'd0);
        exp_wr(32'hD1, 32'd32); exp_resp(32'd32, 0, 0, 0, 4);
        issue(f_vsetvli(11'h0D1, 5'd5, 5'd1), 32'd100, 32'd0);
        wait_quiet("clamp_cases");

        // csr_done timing: never, last WAIT cycle, one cycle too late
        done_delay = -1;
        exp_wr(32'h11, 32'd5); exp_resp(32'd0, 0, 0, 1, 18);
        issue(f_vsetvli(11'h011, 5'd5, 5'd1), 32'd5, 32'd0);
        wait_quiet("timeout");
        done_delay = 14;
        exp_wr(32'h11, 32'd5); exp_resp(32'd5, 0, 0, 0, 18);
        issue(f_vsetvli(11'h011, 5'd5, 5'd1), 32'd5, 32'd0);
        wait_quiet("done_last_cycle");
        done_delay = 15;
        exp_wr(32'h11, 32'd6); exp_resp(32'd0, 0, 0, 1, 18);
        issue(f_vsetvli(11'h011, 5'd5, 5'd1), 32'd6, 32'd0);
        wait_quiet("done_too_late");

        // back-to-back with a slow consumer
        done_delay = 0;
        ready_delay = 3;
        exp_wr(32'h11, 32'd32); exp_resp(32'd32, 0, 0, 0, 4);
        exp_wr(32'h00, 32'd9);  exp_resp(32'd9, 0, 0, 0, 4);
        issue(f_vsetvli(11'h011, 5'd5, 5'd1), 32'd100, 32'd0);
        issue(f_vsetivli(10'h000, 5'd9, 5'd1), 32'd0, 32'd0);
        wait_quiet("back_to_back");
        ready_delay = 0;

        // reset while waiting for csr_done
        done_delay = -1;
        exp_wr(32'h11, 32'd32);
        issue(f_vsetvli(11'h011, 5'd5, 5'd1), 32'd100, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'(1));
        chk("midrst_outputs", 64'({csrwr_en, vstart_clr, resp_valid, resp_vill, resp_illegal, resp_timeout}), 64'(0));
        chk("midrst_data", 64'({csr_vl, csr_vtype, resp_rd_val}), 64'(0));
        chk("midrst_wr_seen", 64'(wr_q.size()), 64'(0));
        resp_q.delete();
        wr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        done_delay = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'({req_ready, resp_valid, csrwr_en}), 64'(3'b100));
        exp_wr(32'h11, 32'd32); exp_resp(32'd32, 0, 0, 0, 4);
        issue(f_vsetvli(11'h011, 5'd5, 5'd1), 32'd100, 32'd0);
        wait_quiet("post_rst");

        chk("resp_q_empty", 64'(resp_q.size()), 64'(0));
        chk("wr_q_empty", 64'(wr_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
